// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB-lite encodings, the SRAM slave FSM state type and
//             the byte-lane decode helper used by ahb_sram_slave.
//  Revision : 1.0  initial release
// ============================================================================
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings (only up to a 32-bit word is supported)
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // HRESP encodings
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Slave FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Little-endian byte-lane enables for a transfer of the given size
  // starting at byte offset offs within the word. Misaligned sizes are
  // filtered out before this is used, so only aligned cases matter.
  function automatic logic [3:0] lane_mask(input logic [1:0] offs,
                                           input logic [2:0] size);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << offs;
      HSIZE_HALF: mask = offs[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_mem
//  Purpose  : Byte-lane writable word memory with asynchronous word read.
//             Contents are not reset.
//  Revision : 1.0  initial release
//
//  Ports
//    clk        in   write clock (rising edge)
//    byte_we    in   per-lane write enables, bit n writes wdata[8n+7:8n]
//    word_addr  in   word address shared by write and read
//    wdata      in   write data, little-endian lanes
//    rdata      out  asynchronous read of the addressed word
// ============================================================================
module ahb_sram_mem #(
  parameter int WORD_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic [3:0]                 byte_we,
  input  logic [WORD_ADDR_WIDTH-1:0] word_addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  localparam int DEPTH = 1 << WORD_ADDR_WIDTH;

  // One independent byte-wide array per lane so partial writes never need
  // a read-modify-write.
  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (byte_we[lane]) begin
        lane_mem[word_addr] <= wdata[8*lane +: 8];
      end
    end

    assign rdata[8*lane +: 8] = lane_mem[word_addr];
  end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_slave
//  Purpose  : AHB-lite slave serving a 2^ADDR_WIDTH byte on-chip SRAM with
//             WAIT_STATES wait cycles per data phase and byte/half/word
//             lane writes.
//  Revision : 1.0  initial release
//
//  Build option
//    AHB_SRAM_ERR_EN  defined  : illegal transfers get a two-cycle ERROR.
//                     undefined: illegal transfers complete OKAY, writes are
//                                dropped, reads return 0, HRESP stays OKAY.
//
//  Ports
//    HCLK       in   bus clock
//    HRESET     in   asynchronous active-high reset
//    HSEL       in   slave select
//    HADDR      in   byte address
//    HTRANS     in   transfer type
//    HWRITE     in   1 write / 0 read
//    HSIZE      in   transfer size
//    HWDATA     in   write data (data phase)
//    HREADY     in   bus-level ready
//    HRDATA     out  read data, zero outside a completing read
//    HREADYOUT  out  this slave's ready
//    HRESP      out  transfer response
// ============================================================================
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  import ahb_pkg::*;

  // Address-phase capture
  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    pend;
  logic                    pend_write;
  logic                    pend_illegal;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [2:0]              pend_size;
  logic                    hreadyout_q;
  logic [1:0]              hresp_q;

  logic                    accept;
  logic                    illegal;
  logic                    completing;
  logic [3:0]              byte_we;
  logic [31:0]             mem_rdata;

  // Only sample a new address phase while this slave is ready; in WAIT/ERR
  // the bus HREADY is low anyway, this just keeps a misbehaving HREADY from
  // corrupting an in-flight data phase.
  assign accept = (state == ST_IDLE) && HSEL && HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  assign illegal = (HADDR[31:ADDR_WIDTH] != '0) ||
                   (HSIZE > HSIZE_WORD) ||
                   ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                   ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

  // The data phase completes in the first IDLE cycle with a pending transfer.
  assign completing = (state == ST_IDLE) && pend;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      pend         <= 1'b0;
      pend_write   <= 1'b0;
      pend_illegal <= 1'b0;
      pend_addr    <= '0;
      pend_size    <= HSIZE_BYTE;
      hreadyout_q  <= 1'b1;
      hresp_q      <= HRESP_OKAY;
    end else begin
      if (accept) begin
        pend         <= 1'b1;
        pend_write   <= HWRITE;
        pend_illegal <= illegal;
        pend_addr    <= HADDR[ADDR_WIDTH-1:0];
        pend_size    <= HSIZE;
      end else if (completing) begin
        pend <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          if (accept) begin
`ifdef AHB_SRAM_ERR_EN
            if (illegal) begin
              state       <= ST_ERR;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else
`endif
            if (WAIT_STATES > 0) begin
              state       <= ST_WAIT;
              wait_cnt    <= 4'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR: begin
          // ERROR is held into the completing IDLE cycle; IDLE clears it.
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Writes commit on the edge that ends the completing cycle.
  assign byte_we = (completing && pend_write && !pend_illegal)
                 ? lane_mask(pend_addr[1:0], pend_size) : 4'b0000;

  ahb_sram_mem #(
    .WORD_ADDR_WIDTH(ADDR_WIDTH - 2)
  ) u_mem (
    .clk       (HCLK),
    .byte_we   (byte_we),
    .word_addr (pend_addr[ADDR_WIDTH-1:2]),
    .wdata     (HWDATA),
    .rdata     (mem_rdata)
  );

  assign HRDATA    = (completing && !pend_write && !pend_illegal) ? mem_rdata : 32'h0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_sram_slave
//  Purpose  : Directed self-checking bench for ahb_sram_slave. Two instances
//             share the bus signals: dut0 with no wait states, dut1 with
//             three. Each has its own HSEL bit and HREADY looped from its
//             own HREADYOUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  hsel = 2'b00;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b000;
  logic [31:0] hwdata = 32'h0;

  logic [31:0] hrdata0, hrdata1;
  logic        hrdy0, hrdy1;
  logic [1:0]  hresp0, hresp1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hrdy0),
    .HRDATA(hrdata0), .HREADYOUT(hrdy0), .HRESP(hresp0));

  ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hrdy1),
    .HRDATA(hrdata1), .HREADYOUT(hrdy1), .HRESP(hresp1));

  function automatic logic rdy_of(input int d);
    return (d == 0) ? hrdy0 : hrdy1;
  endfunction
  function automatic logic [1:0] resp_of(input int d);
    return (d == 0) ? hresp0 : hresp1;
  endfunction
  function automatic logic [31:0] data_of(input int d);
    return (d == 0) ? hrdata0 : hrdata1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one address phase to dut d, then follows the data phase until
  // HREADYOUT is high. Returns in the completing cycle (before its ending
  // edge) so the caller may pipeline the next address phase.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int lowcyc,
                      output logic [1:0] resp_low, output logic [1:0] resp_done);
    hsel   = (d == 0) ? 2'b01 : 2'b10;
    htrans = T_NONSEQ;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    tick();
    hsel   = 2'b00;
    htrans = T_IDLE;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hwdata = wdata;
    lowcyc   = 0;
    resp_low = 2'b00;
    while (rdy_of(d) == 1'b0 && lowcyc < 20) begin
      if (lowcyc == 0) resp_low = resp_of(d);
      lowcyc++;
      tick();
    end
    if (lowcyc >= 20) begin
      checks++;
      fails++;
      $error("FAIL timeout observed=%0d expected<20", lowcyc);
    end
    rdata     = data_of(d);
    resp_done = resp_of(d);
  endtask

  logic [31:0] rd;
  int          lc;
  logic [1:0]  rl, rdn;

  initial begin
    // ---------------- reset values ----------------
    #1 rst = 1'b1;
    #7;
    check("rst_rdy0",  {31'h0, hrdy0}, 32'h1);
    check("rst_resp0", {30'h0, hresp0}, 32'h0);
    check("rst_data0", hrdata0, 32'h0);
    check("rst_rdy1",  {31'h0, hrdy1}, 32'h1);
    check("rst_resp1", {30'h0, hresp1}, 32'h0);
    check("rst_data1", hrdata1, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // ---------------- W=0 back-to-back write then read ----------------
    xfer(0, 1'b1, 32'h010, SZ_W, 32'hDEADBEEF, rd, lc, rl, rdn);
    check("b2b_wr_low", lc, 0);
    xfer(0, 1'b0, 32'h010, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("b2b_rd_low", lc, 0);
    check("b2b_rd_data", rd, 32'hDEADBEEF);
    check("b2b_rd_resp", {30'h0, rdn}, 32'h0);
    tick();
    check("idle_rdata_zero", hrdata0, 32'h0);

    // ---------------- byte / halfword lanes ----------------
    xfer(0, 1'b1, 32'h010, SZ_W, 32'h11223344, rd, lc, rl, rdn);
    xfer(0, 1'b1, 32'h012, SZ_B, 32'h00AA0000, rd, lc, rl, rdn);
    xfer(0, 1'b0, 32'h010, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("byte_lane2", rd, 32'h11AA3344);
    xfer(0, 1'b1, 32'h010, SZ_H, 32'h00005566, rd, lc, rl, rdn);
    xfer(0, 1'b0, 32'h010, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("half_low", rd, 32'h11AA5566);
    xfer(0, 1'b1, 32'h012, SZ_H, 32'h77880000, rd, lc, rl, rdn);
    xfer(0, 1'b0, 32'h010, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("half_high", rd, 32'h77885566);
    tick();

    // ---------------- IDLE / BUSY / HSEL=0 never write ----------------
    xfer(0, 1'b1, 32'h030, SZ_W, 32'h55555555, rd, lc, rl, rdn);
    tick();
    hsel = 2'b01; htrans = T_IDLE; hwrite = 1'b1; haddr = 32'h030; hsize = SZ_W;
    tick();
    hwdata = 32'hFFFFFFFF;
    check("idle_rdy",  {31'h0, hrdy0}, 32'h1);
    check("idle_resp", {30'h0, hresp0}, 32'h0);
    htrans = T_BUSY;
    tick();
    check("busy_rdy",  {31'h0, hrdy0}, 32'h1);
    check("busy_resp", {30'h0, hresp0}, 32'h0);
    hsel = 2'b00; htrans = T_NONSEQ;
    tick();
    check("nosel_rdy",  {31'h0, hrdy0}, 32'h1);
    check("nosel_resp", {30'h0, hresp0}, 32'h0);
    htrans = T_IDLE; hwrite = 1'b0;
    tick();
    xfer(0, 1'b0, 32'h030, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("nowrite_data", rd, 32'h55555555);
    tick();

    // ---------------- illegal transfers ----------------
    xfer(0, 1'b1, 32'h000, SZ_W, 32'h01020304, rd, lc, rl, rdn);
    xfer(0, 1'b0, 32'h013, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("misalign_rdata", rd, 32'h0);
`ifdef AHB_SRAM_ERR_EN
    check("misalign_low",  lc, 1);
    check("misalign_resp1", {30'h0, rl}, 32'h1);
    check("misalign_resp2", {30'h0, rdn}, 32'h1);
`else
    check("misalign_low",  lc, 0);
    check("misalign_resp", {30'h0, rdn}, 32'h0);
`endif
    xfer(0, 1'b1, 32'h1000, SZ_W, 32'hFFFFFFFF, rd, lc, rl, rdn);
`ifdef AHB_SRAM_ERR_EN
    check("oob_low",  lc, 1);
    check("oob_resp", {30'h0, rdn}, 32'h1);
`else
    check("oob_low",  lc, 0);
    check("oob_resp", {30'h0, rdn}, 32'h0);
`endif
    xfer(0, 1'b0, 32'h000, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("oob_unchanged", rd, 32'h01020304);
    check("after_err_resp", {30'h0, rdn}, 32'h0);
    tick();

    // ---------------- W=3 wait states and pipelining ----------------
    xfer(1, 1'b1, 32'h040, SZ_W, 32'hA5A5A5A5, rd, lc, rl, rdn);
    check("w3_wr_low", lc, 3);
    xfer(1, 1'b0, 32'h040, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("w3_rd_low", lc, 3);
    check("w3_rd_data", rd, 32'hA5A5A5A5);
    tick();

    // ---------------- reset during wait cycles ----------------
    xfer(1, 1'b1, 32'h020, SZ_W, 32'hCAFEF00D, rd, lc, rl, rdn);
    tick();
    hsel = 2'b10; htrans = T_NONSEQ; hwrite = 1'b1; haddr = 32'h020; hsize = SZ_W;
    tick();
    hsel = 2'b00; htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'h12345678;
    check("mid_wait_rdy", {31'h0, hrdy1}, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_rdy",  {31'h0, hrdy1}, 32'h1);
    check("async_rst_resp", {30'h0, hresp1}, 32'h0);
    check("async_rst_data", hrdata1, 32'h0);
    #1 rst = 1'b0;
    tick();
    xfer(1, 1'b0, 32'h020, SZ_W, 32'h0, rd, lc, rl, rdn);
    check("rst_abort_data", rd, 32'hCAFEF00D);
    check("rst_abort_low", lc, 3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
